tb_scheduler: RTL

TB_SCHEDULER -- requirements
Module: tb_scheduler

---
 rtl/tb_scheduler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/tb_scheduler.sv
// Traceback job scheduler: turns DP traceback-ready events into engine jobs through a
// 2-deep queue, supervises each job with a timeout and forwards engine reads to the DP.
module tb_scheduler #(
  parameter int ADDRESS_WIDTH   = 10,
  parameter int MEM_BLOCK_WIDTH = 4,
  parameter int TIMEOUT         = 4096
) (
  input  logic                       clk,
  input  logic                       reset_i,
  input  logic                       tb_valid,
  input  logic                       array_num,
  input  logic [ADDRESS_WIDTH-1:0]   tb_x,
  input  logic [ADDRESS_WIDTH-1:0]   tb_y,
  output logic                       tb_busy,
  output logic                       eng_start,
  output logic                       eng_bank,
  output logic [ADDRESS_WIDTH-1:0]   eng_x,
  output logic [ADDRESS_WIDTH-1:0]   eng_y,
  input  logic                       eng_done,
  input  logic                       eng_rd_req,
  input  logic [MEM_BLOCK_WIDTH-1:0] eng_rd_block,
  input  logic [ADDRESS_WIDTH-1:0]   eng_rd_col,
  output logic [MEM_BLOCK_WIDTH-1:0] mem_block_num,
  output logic [ADDRESS_WIDTH-1:0]   column_num,
  output logic                       eng_rd_valid,
  output logic [15:0]                jobs_done,
  output logic                       tb_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int JOB_W = 2 * ADDRESS_WIDTH + 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DISPATCH, WAIT_DONE} state_t;

  state_t             state, state_next;
  logic               tb_valid_q;
  logic               tb_event, push, pop, drop;
  logic [JOB_W-1:0]   fifo_mem [2];
  logic               rd_ptr, wr_ptr;
  logic [1:0]         count;
  logic [JOB_W-1:0]   head;
  logic [JOB_W-1:0]   job_q;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               at_limit, job_end, timed_out;
  logic               rd_accept, rd_stage;

  // Reset gates the event term so tb_busy stays low while reset is held.
  assign tb_event  = tb_valid & ~tb_valid_q & ~reset_i;
  assign pop       = (state == DISPATCH);
  assign push      = tb_event & ((count != 2'd2) | pop);
  assign drop      = tb_event & (count == 2'd2) & ~pop;
  assign head      = fifo_mem[rd_ptr];
  assign at_limit  = (tmo_cnt == TMO_LAST);
  assign job_end   = (state == WAIT_DONE) & (eng_done | at_limit);
  assign timed_out = (state == WAIT_DONE) & ~eng_done & at_limit;
  assign rd_accept = (state == WAIT_DONE) & eng_rd_req;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (count != 2'd0) state_next = DISPATCH;
      DISPATCH:  state_next = WAIT_DONE;
      WAIT_DONE: if (job_end) state_next = ((count != 2'd0) | push) ? DISPATCH : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Job parameters come straight from the queue head in the dispatch cycle so they are
  // valid alongside eng_start, then from the held copy until the job ends.
  always_comb begin
    eng_start = (state == DISPATCH);
    tb_busy   = (state != IDLE) | (count != 2'd0) | tb_event;
    if (state == DISPATCH) {eng_bank, eng_x, eng_y} = head;
    else                   {eng_bank, eng_x, eng_y} = job_q;
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {array_num, tb_x, tb_y};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      tb_valid_q <= 1'b0;
      job_q      <= '0;
      tmo_cnt    <= '0;
      jobs_done  <= 16'd0;
      tb_err     <= 1'b0;
    end else begin
      tb_valid_q <= tb_valid;
      if (state == DISPATCH) begin
        job_q   <= head;
        tmo_cnt <= '0;
      end else if (state == WAIT_DONE && !at_limit) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (state == WAIT_DONE && eng_done) jobs_done <= jobs_done + 16'd1;
      if (drop || timed_out) tb_err <= 1'b1;
    end
  end

  // Two-stage read path: address register, then one cycle for the DP memory read.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      mem_block_num <= '0;
      column_num    <= '0;
      rd_stage      <= 1'b0;
      eng_rd_valid  <= 1'b0;
    end else begin
      if (rd_accept) begin
        mem_block_num <= eng_rd_block;
        column_num    <= eng_rd_col;
      end
      rd_stage     <= rd_accept;
      eng_rd_valid <= rd_stage;
    end
  end

endmodule
